spot_frame_writer: RTL
======================

// Module: spot_frame_writer
// PURPOSE
//  Upstream stage of the spot finder. Packs the 8-bit camera pixel stream into 256-bit kernels of 32 pixels.
//  Writes the kernels, line by line, into the spot finder block RAM.
//  Measures the frame geometry (cam_kernels_x, cam_lines_y) and hands a complete frame to the finder.
//  Holds the finished frame until the finder reports analysis_rdy, so the RAM is never overwritten mid-analysis.
// PARAMETERS
//  KERNEL_PIXELS  32     pixels per RAM word; fixed, because the word width is 256 = 32*8
//  MEM_DEPTH      16384  RAM words addressable through wr_address[13:0]
// PORTS
//  clk_in         in   1    single clock
//  reset          in   1    synchronous, active-low (0 = reset)
//  frame_valid    in   1    camera frame enable; high for the whole frame
//  line_valid     in   1    camera line enable; high for the active pixels of one line
//  pixel_valid    in   1    pixel_data is valid this cycle; only sampled while line_valid=1
//  pixel_data     in   8    pixel brightness
//  analysis_rdy   in   1    1-cycle pulse from the spot finder: analysis of the held frame is complete
//  wr_en          out  1    RAM write strobe
//  wr_address     out  14   RAM word address
//  wr_data        out  256  kernel; pixel n of the kernel occupies bits [8n+7:8n]
//  cam_kernels_x  out  16   kernels per line of the last completed frame
//  cam_lines_y    out  16   lines of the last completed frame
//  frame_rdy      out  1    high while a complete frame is held in RAM for the finder
//  overflow       out  1    sticky per frame: the frame needed more than MEM_DEPTH words
//  frames_dropped out  8    frames ignored while frame_rdy=1; saturates at 255
// BEHAVIOUR
//  Reset (reset=0 at a clk_in edge):
//   - All outputs are 0; pixel counter, word address and line counter are 0.
//   - State goes to ARM. A frame that is in progress is abandoned.
//  States:
//   - ARM: wait for frame_valid=0, then go to IDLE. Prevents capturing a partial frame.
//   - IDLE: on frame_valid=1, clear the address, pixel counter, line counter and overflow flag; go to CAPTURE.
//   - CAPTURE: accept pixels on cycles with line_valid & pixel_valid.
//      - Pixel k of a line goes into byte (k mod 32) of the shift/pack register.
//      - When the 32nd pixel is accepted, the next cycle has wr_en=1, wr_data=packed word, wr_address=current address.
//        The address then increments.
//      - line_valid falling with a partial kernel (1..31 pixels): flush the word on the next cycle, unused bytes 0.
//      - Every line_valid falling edge increments the line counter, but only if the line had at least 1 pixel.
//      - The first line's kernel count = ceil(pixels/32), latched internally.
//      - frame_valid falling: if a line is still open, end it first, same as a line_valid fall.
//        Then load cam_kernels_x and cam_lines_y and go to HOLD with frame_rdy=1.
//        frame_rdy=1 is set 1 cycle after the final word write, or 1 cycle after the fall if no flush is needed.
//   - HOLD: frame_rdy=1, wr_en=0.
//      - On analysis_rdy=1: frame_rdy=0 and go to IDLE next cycle.
//      - A frame_valid rising edge seen in HOLD increments frames_dropped (saturating). That frame is never written.
//      - If analysis_rdy arrives while frame_valid=1, go to ARM instead of IDLE.
//  Arithmetic:
//   - Address is 14 bits.
//   - A write needing address >= MEM_DEPTH is suppressed (wr_en stays 0) and sets overflow=1.
//   - Capture continues counting lines; the address does not wrap.
//   - Line counter saturates at 16'hFFFF.
//  Simultaneous events:
//   - analysis_rdy outside HOLD is ignored.
//   - line_valid falling on the same cycle as the 32nd pixel gives a single write, not two.
//   - Pixels accepted while line_valid=0 are ignored.
//  Latency: the last pixel of a kernel reaches wr_data/wr_en 1 cycle after acceptance.
// TESTING
//  1. Frame of 2 lines x 64 px, px value = index&0xFF -> 4 writes, addr 0..3.
//     Word0 bits[7:0]=0x00, bits[255:248]=0x1F. kernels_x=2, lines_y=2, frame_rdy=1.
//  2. Line of 40 px, 1 line -> 2 writes. Word1 bytes 0..7 = px32..39, bytes 8..31 = 0. kernels_x=2.
//  3. Second frame while frame_rdy=1 -> no wr_en, frames_dropped=1.
//     Then analysis_rdy pulse -> frame_rdy=0 next cycle; the third frame is captured from addr 0.
//  4. Frame of 513 lines x 1024 px (16416 words) -> writes stop after addr 16383, overflow=1, lines_y=513.
//  5. reset=0 mid-line after 10 px -> outputs 0 next edge.
//     frame_valid still high on release -> no writes until frame_valid drops and rises again.
//  6. line_valid drops on the 32nd-pixel cycle -> exactly one write; line counter +1.

Source files
------------

// File: rtl/spot_frame_writer.sv
// rtl/spot_frame_writer.sv - packs camera pixels into 32-pixel kernels and writes them to the spot finder RAM
// Measures frame geometry and holds a finished frame until the finder releases it.
module spot_frame_writer #(
  parameter int KERNEL_PIXELS = 32,
  parameter int MEM_DEPTH     = 16384
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         frame_valid,
  input  logic         line_valid,
  input  logic         pixel_valid,
  input  logic [7:0]   pixel_data,
  input  logic         analysis_rdy,
  output logic         wr_en,
  output logic [13:0]  wr_address,
  output logic [255:0] wr_data,
  output logic [15:0]  cam_kernels_x,
  output logic [15:0]  cam_lines_y,
  output logic         frame_rdy,
  output logic         overflow,
  output logic [7:0]   frames_dropped
);

  localparam int          WORD_W = 8 * KERNEL_PIXELS;
  localparam int          PIX_W  = $clog2(KERNEL_PIXELS);
  localparam logic [14:0] DEPTH  = 15'(MEM_DEPTH);

  typedef enum logic [2:0] {S_ARM, S_IDLE, S_CAPTURE, S_FINISH, S_HOLD} state_t;

  state_t              state_q;
  logic [WORD_W-1:0]   pack_q;
  logic [WORD_W-1:0]   pack_d;
  logic [PIX_W-1:0]    pix_cnt_q;
  logic [14:0]         addr_q;
  logic [15:0]         lines_q;
  logic [15:0]         kcnt_q;
  logic [15:0]         kx_q;
  logic                first_done_q;
  logic                line_pix_q;
  logic                lv_q;
  logic                fv_q;

  logic                in_line;
  logic                accept;
  logic                line_end;
  logic                frame_end;
  logic                word_full;
  logic                flush;
  logic                emit;
  logic                can_write;
  logic [WORD_W-1:0]   emit_data;

  // A line counts as open only inside the frame, so a frame_valid fall closes it too.
  assign in_line   = line_valid & frame_valid;
  assign accept    = (state_q == S_CAPTURE) & in_line & pixel_valid;
  assign line_end  = (state_q == S_CAPTURE) & lv_q & ~in_line;
  assign frame_end = (state_q == S_CAPTURE) & ~frame_valid;
  assign word_full = accept & (pix_cnt_q == PIX_W'(KERNEL_PIXELS - 1));
  assign flush     = line_end & (pix_cnt_q != '0);
  assign emit      = word_full | flush;
  assign can_write = addr_q < DEPTH;
  assign emit_data = word_full ? pack_d : pack_q;

  always_comb begin
    pack_d = pack_q;
    pack_d[{pix_cnt_q, 3'b000} +: 8] = pixel_data;
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q        <= S_ARM;
      pack_q         <= '0;
      pix_cnt_q      <= '0;
      addr_q         <= '0;
      lines_q        <= '0;
      kcnt_q         <= '0;
      kx_q           <= '0;
      first_done_q   <= 1'b0;
      line_pix_q     <= 1'b0;
      lv_q           <= 1'b0;
      fv_q           <= 1'b0;
      wr_en          <= 1'b0;
      wr_address     <= '0;
      wr_data        <= '0;
      cam_kernels_x  <= '0;
      cam_lines_y    <= '0;
      frame_rdy      <= 1'b0;
      overflow       <= 1'b0;
      frames_dropped <= '0;
    end else begin
      lv_q  <= in_line;
      fv_q  <= frame_valid;
      wr_en <= 1'b0;
      case (state_q)
        S_ARM: begin
          if (!frame_valid) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (frame_valid) begin
            addr_q       <= '0;
            pix_cnt_q    <= '0;
            pack_q       <= '0;
            lines_q      <= '0;
            kcnt_q       <= '0;
            kx_q         <= '0;
            first_done_q <= 1'b0;
            line_pix_q   <= 1'b0;
            overflow     <= 1'b0;
            state_q      <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (accept) begin
            pack_q     <= word_full ? '0 : pack_d;
            pix_cnt_q  <= pix_cnt_q + PIX_W'(1);
            line_pix_q <= 1'b1;
            if (word_full && kcnt_q != 16'hFFFF) kcnt_q <= kcnt_q + 16'd1;
          end
          // The address saturates at MEM_DEPTH; excess words are dropped, not wrapped.
          if (emit) begin
            if (can_write) begin
              wr_en      <= 1'b1;
              wr_address <= addr_q[13:0];
              wr_data    <= emit_data;
              addr_q     <= addr_q + 15'd1;
            end else begin
              overflow   <= 1'b1;
            end
          end
          if (line_end) begin
            pack_q     <= '0;
            pix_cnt_q  <= '0;
            kcnt_q     <= '0;
            line_pix_q <= 1'b0;
            if (line_pix_q) begin
              if (lines_q != 16'hFFFF) lines_q <= lines_q + 16'd1;
              if (!first_done_q) begin
                first_done_q <= 1'b1;
                kx_q         <= kcnt_q + {15'd0, flush};
              end
            end
          end
          if (frame_end) state_q <= S_FINISH;
        end
        S_FINISH: begin
          cam_kernels_x <= kx_q;
          cam_lines_y   <= lines_q;
          frame_rdy     <= 1'b1;
          state_q       <= S_HOLD;
        end
        S_HOLD: begin
          if (frame_valid && !fv_q && frames_dropped != 8'hFF)
            frames_dropped <= frames_dropped + 8'd1;
          if (analysis_rdy) begin
            frame_rdy <= 1'b0;
            state_q   <= frame_valid ? S_ARM : S_IDLE;
          end
        end
        default: state_q <= S_ARM;
      endcase
    end
  end

endmodule
